mc_sequencer: RTL and testbench
===============================

// Module: mc_sequencer
// PURPOSE
//  Parametrised multi-cycle control sequencer; next-generation control unit for the multicycle computer.
//  Replaces fixed-delay memory timing with req/ack handshakes on instruction and data memory.
//  Adds run/halt control and a wait-state timeout that enters a sticky FAULT state.
//  Sits between the instruction decoder (op_class) and the datapath muxes, registers and memories.
// PARAMETERS
//  MEM_TIMEOUT  16  max ack wait cycles per request before FAULT (>=1)
//  TO_W         5   width of wait counter; must hold MEM_TIMEOUT
//  CNT_W        32  width of performance counters
// PORTS
//  clk          in   1      system clock, rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  run          in   1      1 = execute; 0 = stop at the next instruction boundary
//  op_class     in   3      from decoder: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 HALT, 6-7 illegal
//  alu_zero     in   1      ALU zero flag
//  imem_req     out  1      instruction fetch request; held until imem_ack
//  imem_ack     in   1      instruction data valid this cycle
//  dmem_req     out  1      data memory request; held until dmem_ack
//  dmem_we      out  1      1 = store request
//  dmem_ack     in   1      data access complete (read data valid)
//  ir_write     out  1      instruction register load strobe
//  pc_write     out  1      PC load strobe
//  pc_src       out  2      0 alu_out, 1 alu_out_buffer, 2 jump addr, 3 reset vector
//  alu_src_a    out  1      0 PC, 1 regA
//  alu_src_b    out  2      0 regB, 1 const 4, 2 sign-ext imm, 3 imm<<2
//  alu_op_sel   out  2      0 add, 1 sub, 2 function field
//  reg_write    out  1      register file write strobe
//  mem_to_reg   out  1      1 = write-back data from the data register
//  reg_dst      out  1      1 = destination field, 0 = n field
//  state        out  3      current state encoding (debug)
//  halted       out  1      1 in HALT state
//  fault        out  1      1 in FAULT state
//  retired_cnt  out  CNT_W  instructions retired
//  stall_cnt    out  CNT_W  memory wait cycles
// BEHAVIOUR
//  - States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
//  - Reset (async): state=IDLE. All outputs 0, including counters and the wait counter.
//  - All control outputs are Moore-decoded from state and the latched class, except ack-qualified strobes.
//    Strobes not listed for a state are 0.
//  - IDLE: if run=1, assert pc_write=1, pc_src=3 for one cycle, then go to FETCH.
//  - FETCH: if run=0 on entry, return to IDLE.
//    Otherwise imem_req=1, alu_src_a=0, alu_src_b=1, alu_op_sel=0.
//    On the imem_ack cycle: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
//  - DECODE: alu_src_a=0, alu_src_b=3, add (branch target into ALU buffer). Latch op_class.
//    ALU/LOAD/STORE/BRANCH -> EXEC.
//    JUMP -> pc_write=1, pc_src=2, retire, -> FETCH.
//    HALT -> retire, -> HALT. Illegal -> FAULT.
//  - EXEC ALU: src_a=1, src_b=0, op=2, -> WB.
//  - EXEC LOAD/STORE: src_a=1, src_b=2, add, -> MEM.
//  - EXEC BRANCH: src_a=1, src_b=0, sub, pc_src=1, pc_write=alu_zero, retire, -> FETCH.
//  - MEM: dmem_req=1, dmem_we=(class==STORE). On dmem_ack: LOAD -> WB; STORE -> retire, -> FETCH.
//  - WB: reg_write=1, mem_to_reg=(LOAD), reg_dst=(ALU), retire, -> FETCH.
//  - Timeout: the wait counter clears when a request starts and increments each req&!ack cycle.
//    Reaching MEM_TIMEOUT -> FAULT. An ack in the same cycle wins; no fault.
//  - HALT: exit to IDLE only when run=0. FAULT is sticky until reset_n.
//  - Dropping run mid-instruction completes the instruction; the stop is taken at FETCH entry.
//  - req stays asserted, and addresses stay stable, until ack. req never drops without ack, except on reset.
// CONFIGURATION
//  - MC_SEQ_PERF_CNT_EN defined: retired_cnt +1 per retire; stall_cnt +1 per req&!ack cycle.
//    Both saturate at all-ones and clear on reset.
//  - Not defined: retired_cnt and stall_cnt are tied to 0. The ports are retained.
// STRUCTURE
//  - Add to params.v: state codes, op_class codes, pc_src / alu_src / alu_op_sel codes.
//  - Sub-module mc_seq_timeout: wait counter with start, count and expired outputs, parametrised by MEM_TIMEOUT.
// TESTING
//  - Reset, then run=1, ALU op, imem_ack after 0 wait:
//    IDLE, FETCH, DECODE, EXEC, WB, FETCH (5 cycles after IDLE); reg_write=1, reg_dst=1 only in WB.
//  - LOAD with dmem_ack after 3 waits: MEM lasts 4 cycles.
//    mem_to_reg=1 in WB; stall_cnt=3 (with the macro defined).
//  - BRANCH with alu_zero=1: pc_write=1, pc_src=1 in EXEC.
//    With alu_zero=0: pc_write stays 0. retired_cnt +1 in both cases.
//  - MEM_TIMEOUT=4 and imem_ack never asserted: FAULT after 4 wait cycles. It stays in FAULT with run toggled.
//    A reset_n pulse returns to IDLE.
//  - HALT op: halted=1 and persists with run=1; run=0 -> IDLE; run=1 -> reset-vector load (pc_src=3).
//  - run dropped in EXEC of a STORE: the store completes with one dmem_req and dmem_we=1, then IDLE. No new fetch.

Source files
------------

// File: rtl/mc_sequencer_pkg.sv
// Shared encodings for the multicycle control sequencer: FSM state codes,
// decoder op_class codes and the datapath mux select codes.
package mc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_e;

    // Codes 6 and 7 are illegal and lead to FAULT.
    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_BRANCH = 3'd3,
        OP_JUMP   = 3'd4,
        OP_HALT   = 3'd5
    } op_class_e;

    localparam logic [1:0] PC_SRC_ALU_OUT = 2'd0;
    localparam logic [1:0] PC_SRC_ALU_BUF = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP    = 2'd2;
    localparam logic [1:0] PC_SRC_RESET   = 2'd3;

    localparam logic       SRC_A_PC       = 1'b0;
    localparam logic       SRC_A_REG      = 1'b1;

    localparam logic [1:0] SRC_B_REG      = 2'd0;
    localparam logic [1:0] SRC_B_FOUR     = 2'd1;
    localparam logic [1:0] SRC_B_SIMM     = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SHL2 = 2'd3;

    localparam logic [1:0] ALU_OP_ADD     = 2'd0;
    localparam logic [1:0] ALU_OP_SUB     = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT   = 2'd2;

endpackage

// File: rtl/mc_seq_timeout.sv
// Memory wait-state watchdog. The counter restarts with every new request
// and counts cycles where the request is outstanding without an ack.
// expired_o flags the waiting cycle that brings the count to MEM_TIMEOUT.
module mc_seq_timeout #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start_i,
    input  logic count_i,
    output logic expired_o
);

    localparam logic [TO_W:0] LIMIT = MEM_TIMEOUT[TO_W:0];

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;
    logic [TO_W-1:0] cnt_base;
    logic [TO_W:0]   cnt_inc;

    // Next wait count: restart at a new request, then add one per unacked cycle.
    // NOTE: every variable written here gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        cnt_base  = start_i ? {TO_W{1'b0}} : cnt_q;
        cnt_inc   = {1'b0, cnt_base} + {{TO_W{1'b0}}, count_i};
        cnt_d     = cnt_inc[TO_W-1:0];
        expired_o = count_i && (cnt_inc >= LIMIT);
    end

    // Wait counter register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= {TO_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer with req/ack memory handshakes, run/halt
// control and a sticky FAULT state on memory timeout or illegal op_class.
// Build option: define MC_SEQ_PERF_CNT_EN to enable the saturating
// retired/stall performance counters; otherwise both ports read 0.
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic [2:0]       op_class,
    input  logic             alu_zero,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op_sel,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic [2:0]       state,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e     state_q, state_d;
    logic [2:0] class_q, class_d;
    logic       busy_q;      // a request was outstanding without ack last cycle
    logic       retire;
    logic       wait_start;
    logic       wait_count;
    logic       wait_expired;

    // A fetch starts only if run is high on FETCH entry; once issued it is held to ack.
    assign imem_req   = (state_q == ST_FETCH) && (run || busy_q);
    assign dmem_req   = (state_q == ST_MEM);
    assign wait_start = (imem_req || dmem_req) && !busy_q;
    assign wait_count = (imem_req && !imem_ack) || (dmem_req && !dmem_ack);

    assign state  = state_q;
    assign halted = (state_q == ST_HALT);
    assign fault  = (state_q == ST_FAULT);

    mc_seq_timeout #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) u_timeout (
        .clk       (clk),
        .reset_n   (reset_n),
        .start_i   (wait_start),
        .count_i   (wait_count),
        .expired_o (wait_expired)
    );

    // Next-state and control decode from state and latched class; strobes qualified by acks.
    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        retire     = 1'b0;
        dmem_we    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU_OUT;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_REG;
        alu_op_sel = ALU_OP_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_RESET;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!imem_req) begin
                    state_d = ST_IDLE;
                end else begin
                    alu_src_b = SRC_B_FOUR;
                    if (imem_ack) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end else if (wait_expired) begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_DECODE: begin
                alu_src_b = SRC_B_IMM_SHL2;
                class_d   = op_class;
                case (op_class)
                    OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH: state_d = ST_EXEC;
                    OP_JUMP: begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_JUMP;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    OP_HALT: begin
                        retire  = 1'b1;
                        state_d = ST_HALT;
                    end
                    default: state_d = ST_FAULT;
                endcase
            end
            ST_EXEC: begin
                alu_src_a = SRC_A_REG;
                case (class_q)
                    OP_ALU: begin
                        alu_op_sel = ALU_OP_FUNCT;
                        state_d    = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b = SRC_B_SIMM;
                        state_d   = ST_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op_sel = ALU_OP_SUB;
                        pc_src     = PC_SRC_ALU_BUF;
                        pc_write   = alu_zero;
                        retire     = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    default: state_d = ST_FAULT;
                endcase
            end
            ST_MEM: begin
                dmem_we = (class_q == OP_STORE);
                if (dmem_ack) begin
                    if (class_q == OP_STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (class_q == OP_LOAD);
                reg_dst    = (class_q == OP_ALU);
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_HALT: begin
                if (!run) state_d = ST_IDLE;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // Sequencer state, latched instruction class and outstanding-request flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            class_q <= 3'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            busy_q  <= wait_count;
        end
    end

`ifdef MC_SEQ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] stall_q;

    // Saturating counters of retired instructions and memory wait cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_q <= {CNT_W{1'b0}};
            stall_q   <= {CNT_W{1'b0}};
        end else begin
            if (retire && (retired_q != {CNT_W{1'b1}})) retired_q <= retired_q + CNT_ONE;
            if (wait_count && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + CNT_ONE;
        end
    end

    assign retired_cnt = retired_q;
    assign stall_cnt   = stall_q;
`else
    logic perf_unused;
    assign perf_unused = retire;
    assign retired_cnt = {CNT_W{1'b0}};
    assign stall_cnt   = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: each step drives inputs and pushes the
// expected state, control vector and counters; a negedge monitor pops and
// compares them against the DUT.
`timescale 1ns/1ps
module tb_mc_sequencer;
    import mc_sequencer_pkg::*;

    localparam int CNT_W = 16;
`ifdef MC_SEQ_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op_sel;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       halted;
        logic       fault;
    } ctl_t;

    typedef struct {
        string            tag;
        state_e           st;
        ctl_t             ctl;
        logic [CNT_W-1:0] ret;
        logic [CNT_W-1:0] stl;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             run = 1'b0;
    logic [2:0]       op_class = 3'd0;
    logic             alu_zero = 1'b0;
    logic             imem_req, imem_ack = 1'b0;
    logic             dmem_req, dmem_we, dmem_ack = 1'b0;
    logic             ir_write, pc_write, alu_src_a;
    logic [1:0]       pc_src, alu_src_b, alu_op_sel;
    logic             reg_write, mem_to_reg, reg_dst, halted, fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired_cnt, stall_cnt;
    ctl_t             dut_ctl;

    exp_t sb[$];
    exp_t e_mon;
    int   checks = 0;
    int   errors = 0;
    int   exp_ret = 0;
    int   exp_stall = 0;

    always #5 clk = ~clk;

    mc_sequencer #(.MEM_TIMEOUT(4), .TO_W(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .op_class(op_class), .alu_zero(alu_zero),
        .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .state(state),
        .halted(halted), .fault(fault), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
    );

    assign dut_ctl = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, alu_src_a,
                      alu_src_b, alu_op_sel, reg_write, mem_to_reg, reg_dst, halted, fault};

    // Expected control vectors, written straight from the state table.
    function automatic ctl_t c_none();
        ctl_t c = '0;
        return c;
    endfunction
    function automatic ctl_t c_idle();
        ctl_t c = '0;
        c.pc_write = 1'b1; c.pc_src = 2'd3;
        return c;
    endfunction
    function automatic ctl_t c_fetch(input logic ack);
        ctl_t c = '0;
        c.imem_req = 1'b1; c.alu_src_b = 2'd1;
        if (ack) begin c.ir_write = 1'b1; c.pc_write = 1'b1; c.pc_src = 2'd0; end
        return c;
    endfunction
    function automatic ctl_t c_decode(input logic jump);
        ctl_t c = '0;
        c.alu_src_b = 2'd3;
        if (jump) begin c.pc_write = 1'b1; c.pc_src = 2'd2; end
        return c;
    endfunction
    function automatic ctl_t c_exec_alu();
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_src_b = 2'd0; c.alu_op_sel = 2'd2;
        return c;
    endfunction
    function automatic ctl_t c_exec_mem();
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; c.alu_op_sel = 2'd0;
        return c;
    endfunction
    function automatic ctl_t c_exec_br(input logic z);
        ctl_t c = '0;
        c.alu_src_a = 1'b1; c.alu_op_sel = 2'd1; c.pc_src = 2'd1; c.pc_write = z;
        return c;
    endfunction
    function automatic ctl_t c_mem(input logic we);
        ctl_t c = '0;
        c.dmem_req = 1'b1; c.dmem_we = we;
        return c;
    endfunction
    function automatic ctl_t c_wb(input logic ld, input logic alu);
        ctl_t c = '0;
        c.reg_write = 1'b1; c.mem_to_reg = ld; c.reg_dst = alu;
        return c;
    endfunction
    function automatic ctl_t c_halted();
        ctl_t c = '0;
        c.halted = 1'b1;
        return c;
    endfunction
    function automatic ctl_t c_fault();
        ctl_t c = '0;
        c.fault = 1'b1;
        return c;
    endfunction

    // One clock cycle: drive inputs just after the edge and queue the expectation.
    task automatic step(input string tag, input logic r, input logic [2:0] op, input logic z,
                        input logic ia, input logic da, input state_e es, input ctl_t ec,
                        input logic ret);
        exp_t e;
        @(posedge clk); #1;
        run = r; op_class = op; alu_zero = z; imem_ack = ia; dmem_ack = da;
        e.tag = tag; e.st = es; e.ctl = ec;
        e.ret = PERF_EN ? CNT_W'(exp_ret) : '0;
        e.stl = PERF_EN ? CNT_W'(exp_stall) : '0;
        sb.push_back(e);
        if (ret) exp_ret++;
        if ((ec.imem_req && !ia) || (ec.dmem_req && !da)) exp_stall++;
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        @(posedge clk); #1;
        reset_n = 1'b0; run = 1'b0; op_class = 3'd0; alu_zero = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        exp_ret = 0; exp_stall = 0;
        e.tag = tag; e.st = ST_IDLE; e.ctl = '0; e.ret = '0; e.stl = '0;
        sb.push_back(e);
        @(negedge clk); #1;
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: compares queued expectations against DUT outputs.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            checks++;
            assert (state === e_mon.st) else begin
                errors++;
                $error("FAIL %s state: observed %0d expected %0d", e_mon.tag, state, e_mon.st);
            end
            checks++;
            assert (dut_ctl === e_mon.ctl) else begin
                errors++;
                $error("FAIL %s ctl: observed %h expected %h", e_mon.tag, dut_ctl, e_mon.ctl);
            end
            checks++;
            assert (retired_cnt === e_mon.ret) else begin
                errors++;
                $error("FAIL %s retired_cnt: observed %0d expected %0d", e_mon.tag, retired_cnt, e_mon.ret);
            end
            checks++;
            assert (stall_cnt === e_mon.stl) else begin
                errors++;
                $error("FAIL %s stall_cnt: observed %0d expected %0d", e_mon.tag, stall_cnt, e_mon.stl);
            end
        end
    end

    initial begin
        do_reset("reset");

        // ALU op with zero-wait fetch
        step("alu_idle",   1, OP_ALU, 0, 0, 0, ST_IDLE,   c_idle(),      0);
        step("alu_fetch",  1, OP_ALU, 0, 1, 0, ST_FETCH,  c_fetch(1),    0);
        step("alu_decode", 1, OP_ALU, 0, 0, 0, ST_DECODE, c_decode(0),   0);
        step("alu_exec",   1, OP_ALU, 0, 0, 0, ST_EXEC,   c_exec_alu(),  0);
        step("alu_wb",     1, OP_ALU, 0, 0, 0, ST_WB,     c_wb(0, 1),    1);

        // LOAD with three data wait states; op_class changes after decode must not matter
        step("ld_fetch",   1, OP_LOAD, 0, 1, 0, ST_FETCH,  c_fetch(1),   0);
        step("ld_decode",  1, OP_LOAD, 0, 0, 0, ST_DECODE, c_decode(0),  0);
        step("ld_exec",    1, OP_STORE, 0, 0, 0, ST_EXEC,  c_exec_mem(), 0);
        for (int i = 0; i < 3; i++)
            step("ld_mem_wait", 1, OP_STORE, 0, 0, 0, ST_MEM, c_mem(0), 0);
        step("ld_mem_ack", 1, OP_STORE, 0, 0, 1, ST_MEM,   c_mem(0),     0);
        step("ld_wb",      1, OP_ALU, 0, 0, 0, ST_WB,      c_wb(1, 0),   1);

        // BRANCH taken
        step("brt_fetch",  1, OP_BRANCH, 1, 1, 0, ST_FETCH,  c_fetch(1),   0);
        step("brt_decode", 1, OP_BRANCH, 1, 0, 0, ST_DECODE, c_decode(0),  0);
        step("brt_exec",   1, OP_BRANCH, 1, 0, 0, ST_EXEC,   c_exec_br(1), 1);

        // BRANCH not taken, one fetch wait state
        step("brn_fetch_w", 1, OP_BRANCH, 0, 0, 0, ST_FETCH,  c_fetch(0),   0);
        step("brn_fetch",   1, OP_BRANCH, 0, 1, 0, ST_FETCH,  c_fetch(1),   0);
        step("brn_decode",  1, OP_BRANCH, 0, 0, 0, ST_DECODE, c_decode(0),  0);
        step("brn_exec",    1, OP_BRANCH, 0, 0, 0, ST_EXEC,   c_exec_br(0), 1);

        // JUMP retires from DECODE
        step("jmp_fetch",  1, OP_JUMP, 0, 1, 0, ST_FETCH,  c_fetch(1),  0);
        step("jmp_decode", 1, OP_JUMP, 0, 0, 0, ST_DECODE, c_decode(1), 1);

        // STORE with run dropped in EXEC: completes, then stops without a new fetch
        step("st_fetch",    1, OP_STORE, 0, 1, 0, ST_FETCH,  c_fetch(1),   0);
        step("st_decode",   1, OP_STORE, 0, 0, 0, ST_DECODE, c_decode(0),  0);
        step("st_exec",     0, OP_STORE, 0, 0, 0, ST_EXEC,   c_exec_mem(), 0);
        step("st_mem_wait", 0, OP_LOAD,  0, 0, 0, ST_MEM,    c_mem(1),     0);
        step("st_mem_ack",  0, OP_LOAD,  0, 0, 1, ST_MEM,    c_mem(1),     1);
        step("st_stop",     0, OP_LOAD,  0, 0, 0, ST_FETCH,  c_none(),     0);
        step("st_idle",     0, OP_LOAD,  0, 0, 0, ST_IDLE,   c_none(),     0);

        // HALT: holds with run=1, leaves on run=0, restarts with reset-vector load
        step("h_idle",      1, OP_HALT, 0, 0, 0, ST_IDLE,   c_idle(),     0);
        step("h_fetch",     1, OP_HALT, 0, 1, 0, ST_FETCH,  c_fetch(1),   0);
        step("h_decode",    1, OP_HALT, 0, 0, 0, ST_DECODE, c_decode(0),  1);
        step("h_halt1",     1, OP_HALT, 0, 0, 0, ST_HALT,   c_halted(),   0);
        step("h_halt2",     1, OP_HALT, 0, 0, 0, ST_HALT,   c_halted(),   0);
        step("h_halt_exit", 0, OP_HALT, 0, 0, 0, ST_HALT,   c_halted(),   0);
        step("h_idle2",     1, OP_ALU,  0, 0, 0, ST_IDLE,   c_idle(),     0);

        // Illegal op_class goes to sticky FAULT
        step("ill_fetch",   1, 3'd7, 0, 1, 0, ST_FETCH,  c_fetch(1),  0);
        step("ill_decode",  1, 3'd7, 0, 0, 0, ST_DECODE, c_decode(0), 0);
        step("ill_fault0",  0, 3'd7, 0, 0, 0, ST_FAULT,  c_fault(),   0);
        step("ill_fault1",  1, 3'd7, 0, 0, 0, ST_FAULT,  c_fault(),   0);
        do_reset("reset_ill");

        // Instruction fetch never acknowledged: FAULT after MEM_TIMEOUT=4 wait cycles
        step("to_idle", 1, OP_ALU, 0, 0, 0, ST_IDLE, c_idle(), 0);
        for (int i = 0; i < 4; i++)
            step("to_fetch_wait", 1, OP_ALU, 0, 0, 0, ST_FETCH, c_fetch(0), 0);
        step("to_fault",      1, OP_ALU, 0, 0, 0, ST_FAULT, c_fault(), 0);
        step("to_fault_run0", 0, OP_ALU, 0, 0, 0, ST_FAULT, c_fault(), 0);
        step("to_fault_run1", 1, OP_ALU, 0, 1, 0, ST_FAULT, c_fault(), 0);
        do_reset("reset_to");
        step("to_after_reset", 0, OP_ALU, 0, 0, 0, ST_IDLE, c_none(), 0);

        @(negedge clk); #1;
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
